// File: rtl/icache_nway_pkg.sv
// Shared command codes and controller state for the N-way icache.
package icache_pkg;

  localparam logic [3:0] CMD_RESET      = 4'd8;
  localparam logic [3:0] CMD_INVALIDATE = 4'd3;
  localparam logic [3:0] CMD_INST_FETCH = 4'd2;
  localparam logic [3:0] CMD_PRINT      = 4'd9;

  typedef enum logic [1:0] {
    SWEEP,
    IDLE,
    FILL
  } state_t;

endpackage

// File: rtl/icache_nway_if.sv
// Command, fill and response handshake bundle for icache_nway.
interface icache_nway_if #(
  parameter int ADDR_W      = 32,
  parameter int OFFSET_BITS = 6
);

  logic                      cmd_valid;
  logic                      cmd_ready;
  logic [3:0]                cmd;
  logic [ADDR_W-1:0]         cmd_addr;
  logic                      fill_req;
  logic [ADDR_W-OFFSET_BITS-1:0] fill_addr;
  logic                      fill_ack;
  logic                      rsp_valid;
  logic                      rsp_hit;

  modport master (
    output cmd_valid, cmd, cmd_addr, fill_ack,
    input  cmd_ready, fill_req, fill_addr,
    input  rsp_valid, rsp_hit
  );

  modport slave (
    input  cmd_valid, cmd, cmd_addr, fill_ack,
    output cmd_ready, fill_req, fill_addr,
    output rsp_valid, rsp_hit
  );

endinterface

// File: rtl/icache_lru_age.sv
// Per-set true-LRU age update and victim choice (age 0 = MRU).
module icache_lru_age #(
  parameter int WAYS  = 4,
  parameter int AGE_W = $clog2(WAYS)
) (
  input  logic [WAYS-1:0]            valid,
  input  logic [WAYS-1:0][AGE_W-1:0] age,
  input  logic [AGE_W-1:0]           acc,
  output logic [AGE_W-1:0]           victim,
  output logic [WAYS-1:0][AGE_W-1:0] age_new
);

  always_comb begin
    victim = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (age[w] == AGE_W'(WAYS - 1)) victim = AGE_W'(w);
    end
    // Descending scan so the lowest invalid way wins.
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid[w]) victim = AGE_W'(w);
    end
  end

  always_comb begin
    age_new = age;
    for (int w = 0; w < WAYS; w++) begin
      if (age[w] < age[acc]) age_new[w] = age[w] + 1'b1;
    end
    age_new[acc] = '0;
  end

endmodule

// File: rtl/icache_nway.sv
// N-way set-associative icache model with sweep clear and fill handshake.
// Optional PRINT dump compiled when ICACHE_PRINT_EN is defined.
module icache_nway
  import icache_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int WAYS        = 4,
  parameter int SET_BITS    = 14,
  parameter int OFFSET_BITS = 6,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  icache_nway_if.slave     bus,
  output logic             busy,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt,
  output logic [CNT_W-1:0] read_cnt
);

  localparam int TAG_W = ADDR_W - SET_BITS - OFFSET_BITS;
  localparam int AGE_W = $clog2(WAYS);
  localparam int SETS  = 1 << SET_BITS;

  logic [WAYS-1:0]             valid_q [SETS];
  logic [WAYS-1:0][TAG_W-1:0]  tag_q   [SETS];
  logic [WAYS-1:0][AGE_W-1:0]  age_q   [SETS];

  state_t              state;
  logic [SET_BITS-1:0] sweep_idx;
  logic [SET_BITS-1:0] fill_set;
  logic [TAG_W-1:0]    fill_tag;

  logic [TAG_W-1:0]    cmd_tag;
  logic [SET_BITS-1:0] cmd_set;
  logic [SET_BITS-1:0] lk_set;
  logic [WAYS-1:0]     hit_vec;
  logic [AGE_W-1:0]    hit_way;
  logic                hit;
  logic [AGE_W-1:0]    acc_way;
  logic [AGE_W-1:0]    victim;
  logic [WAYS-1:0][AGE_W-1:0] age_new;

  logic accept;
  logic is_fetch;
  logic is_inv;
  logic is_rst;
  logic fill_done;
  logic unused_off;

  assign cmd_tag = bus.cmd_addr[ADDR_W-1 -: TAG_W];
  assign cmd_set = bus.cmd_addr[OFFSET_BITS +: SET_BITS];
  assign unused_off = ^bus.cmd_addr[OFFSET_BITS-1:0];

  assign accept   = bus.cmd_valid && bus.cmd_ready;
  assign is_fetch = bus.cmd == CMD_INST_FETCH;
  assign is_inv   = bus.cmd == CMD_INVALIDATE;
  assign is_rst   = bus.cmd == CMD_RESET;
  assign fill_done = (state == FILL) && bus.fill_ack;

  always_comb begin
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      hit_vec[w] = valid_q[cmd_set][w] &&
                   (tag_q[cmd_set][w] == cmd_tag);
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (hit_vec[w]) hit_way = AGE_W'(w);
    end
  end

  assign hit     = |hit_vec;
  assign lk_set  = (state == FILL) ? fill_set : cmd_set;
  assign acc_way = (state == FILL) ? victim : hit_way;

  icache_lru_age #(
    .WAYS  (WAYS),
    .AGE_W (AGE_W)
  ) u_lru (
    .valid   (valid_q[lk_set]),
    .age     (age_q[lk_set]),
    .acc     (acc_way),
    .victim  (victim),
    .age_new (age_new)
  );

  // Array storage carries no reset; the sweep clears it.
  always_ff @(posedge clk) begin
    if (state == SWEEP) begin
      valid_q[sweep_idx] <= '0;
      for (int w = 0; w < WAYS; w++) begin
        age_q[sweep_idx][w] <= AGE_W'(w);
      end
    end else if (accept && is_fetch && hit) begin
      age_q[cmd_set] <= age_new;
    end else if (accept && is_inv) begin
      valid_q[cmd_set] <= valid_q[cmd_set] & ~hit_vec;
    end else if (fill_done) begin
      tag_q[fill_set][victim]   <= fill_tag;
      valid_q[fill_set][victim] <= 1'b1;
      age_q[fill_set]           <= age_new;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= SWEEP;
      sweep_idx     <= '0;
      fill_set      <= '0;
      fill_tag      <= '0;
      hit_cnt       <= '0;
      miss_cnt      <= '0;
      read_cnt      <= '0;
      busy          <= 1'b1;
      bus.cmd_ready <= 1'b0;
      bus.fill_req  <= 1'b0;
      bus.fill_addr <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_hit   <= 1'b0;
    end else begin
      bus.rsp_valid <= 1'b0;
      bus.rsp_hit   <= 1'b0;
      unique case (state)
        SWEEP: begin
          sweep_idx <= sweep_idx + 1'b1;
          if (&sweep_idx) begin
            state         <= IDLE;
            busy          <= 1'b0;
            bus.cmd_ready <= 1'b1;
          end
        end
        IDLE: begin
          if (accept) begin
            unique case (1'b1)
              is_fetch: begin
                if (~&read_cnt) read_cnt <= read_cnt + 1'b1;
                if (hit) begin
                  if (~&hit_cnt) hit_cnt <= hit_cnt + 1'b1;
                  bus.rsp_valid <= 1'b1;
                  bus.rsp_hit   <= 1'b1;
                end else begin
                  if (~&miss_cnt) miss_cnt <= miss_cnt + 1'b1;
                  fill_tag      <= cmd_tag;
                  fill_set      <= cmd_set;
                  bus.fill_addr <= bus.cmd_addr[ADDR_W-1:OFFSET_BITS];
                  bus.fill_req  <= 1'b1;
                  bus.cmd_ready <= 1'b0;
                  busy          <= 1'b1;
                  state         <= FILL;
                end
              end
              is_rst: begin
                hit_cnt       <= '0;
                miss_cnt      <= '0;
                read_cnt      <= '0;
                sweep_idx     <= '0;
                bus.cmd_ready <= 1'b0;
                busy          <= 1'b1;
                state         <= SWEEP;
              end
              default: ;
            endcase
          end
        end
        FILL: begin
          if (bus.fill_ack) begin
            bus.fill_req  <= 1'b0;
            bus.rsp_valid <= 1'b1;
            bus.cmd_ready <= 1'b1;
            busy          <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= SWEEP;
      endcase
    end
  end

`ifdef ICACHE_PRINT_EN
  always_ff @(posedge clk) begin
    if (accept && bus.cmd == CMD_PRINT) begin
      $display("icache dump begin");
      for (int s = 0; s < SETS; s++) begin
        if (|valid_q[s]) begin
          $write("set %0d:", s);
          for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_q[s][w])
              $write(" v1 a%0d t%0h", age_q[s][w], tag_q[s][w]);
            else
              $write(" v0 a%0d tX", age_q[s][w]);
          end
          $write("\n");
        end
      end
      $display("icache dump end");
    end
  end
`endif

endmodule

// File: tb/tb_icache_nway.sv
// Directed vector bench for icache_nway (4 ways, 16 sets, 64B lines).
module tb_icache_nway;
  import icache_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        busy;
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
  logic [31:0] read_cnt;

  int tests;
  int fails;

  icache_nway_if #(.ADDR_W(32), .OFFSET_BITS(6)) bus ();

  icache_nway #(
    .ADDR_W      (32),
    .WAYS        (4),
    .SET_BITS    (4),
    .OFFSET_BITS (6),
    .CNT_W       (32)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .busy     (busy),
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt),
    .read_cnt (read_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  c;
    logic [31:0] a;
    logic        eh;
    logic        ck;
    int          er;
    int          ehc;
    int          em;
  } vec_t;

  vec_t tbl [21];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cnt(input string nm, input int r, input int h,
                         input int m);
    chk({nm, "_read"}, read_cnt, r);
    chk({nm, "_hit"}, hit_cnt, h);
    chk({nm, "_miss"}, miss_cnt, m);
  endtask

  task automatic wait_sweep(input string nm);
    int   n;
    logic seen;
    n = 0;
    seen = 1'b0;
    while (!bus.cmd_ready && n < 64) begin
      if (bus.rsp_valid) seen = 1'b1;
      tick();
      n++;
    end
    chk({nm, "_cycles"}, n, 16);
    chk({nm, "_no_rsp"}, seen, 0);
    chk({nm, "_busy"}, busy, 0);
  endtask

  task automatic send(input logic [3:0] c, input logic [31:0] a,
                      output logic h);
    int n;
    h = 1'b0;
    n = 0;
    while (!bus.cmd_ready && n < 64) begin
      tick();
      n++;
    end
    if (!bus.cmd_ready) begin
      chk("ready_timeout", 0, 1);
      return;
    end
    bus.cmd_valid = 1'b1;
    bus.cmd = c;
    bus.cmd_addr = a;
    tick();
    bus.cmd_valid = 1'b0;
    if (c != CMD_INST_FETCH) begin
      chk("no_rsp", bus.rsp_valid, 0);
      return;
    end
    if (bus.rsp_valid) begin
      h = bus.rsp_hit;
      return;
    end
    chk("fill_req", bus.fill_req, 1);
    chk("fill_addr", bus.fill_addr, a >> 6);
    repeat (2) tick();
    chk("fill_hold", bus.fill_addr, a >> 6);
    bus.fill_ack = 1'b1;
    tick();
    bus.fill_ack = 1'b0;
    chk("fill_drop", bus.fill_req, 0);
    chk("miss_rsp", bus.rsp_valid, 1);
    h = bus.rsp_hit;
  endtask

  initial begin
    logic h;
    tests = 0;
    fails = 0;

    tbl[0]  = '{CMD_INST_FETCH, 32'h1000, 0, 0, 0, 0, 0};
    tbl[1]  = '{CMD_INST_FETCH, 32'h1000, 1, 1, 2, 1, 1};
    tbl[2]  = '{CMD_RESET,      32'h0000, 0, 0, 0, 0, 0};
    tbl[3]  = '{CMD_INST_FETCH, 32'h0000, 0, 0, 0, 0, 0};
    tbl[4]  = '{CMD_INST_FETCH, 32'h0400, 0, 0, 0, 0, 0};
    tbl[5]  = '{CMD_INST_FETCH, 32'h0800, 0, 0, 0, 0, 0};
    tbl[6]  = '{CMD_INST_FETCH, 32'h0C00, 0, 0, 0, 0, 0};
    tbl[7]  = '{CMD_INST_FETCH, 32'h0000, 1, 0, 0, 0, 0};
    tbl[8]  = '{CMD_INST_FETCH, 32'h1000, 0, 0, 0, 0, 0};
    tbl[9]  = '{CMD_INST_FETCH, 32'h0400, 0, 0, 0, 0, 0};
    tbl[10] = '{CMD_INST_FETCH, 32'h0000, 1, 1, 8, 2, 6};
    tbl[11] = '{CMD_INST_FETCH, 32'h0800, 0, 0, 0, 0, 0};
    tbl[12] = '{CMD_INVALIDATE, 32'h0000, 0, 0, 0, 0, 0};
    tbl[13] = '{CMD_INST_FETCH, 32'h0000, 0, 0, 0, 0, 0};
    tbl[14] = '{CMD_INVALIDATE, 32'h7C00, 0, 0, 0, 0, 0};
    tbl[15] = '{CMD_INST_FETCH, 32'h0000, 1, 0, 0, 0, 0};
    tbl[16] = '{CMD_INST_FETCH, 32'h0400, 1, 0, 0, 0, 0};
    tbl[17] = '{CMD_INST_FETCH, 32'h0800, 1, 0, 0, 0, 0};
    tbl[18] = '{CMD_INST_FETCH, 32'h1000, 1, 1, 14, 6, 8};
    tbl[19] = '{CMD_PRINT,      32'h0000, 0, 0, 0, 0, 0};
    tbl[20] = '{CMD_INST_FETCH, 32'h0000, 1, 1, 15, 7, 8};

    rst_n = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd = 4'd0;
    bus.cmd_addr = '0;
    bus.fill_ack = 1'b0;
    repeat (2) tick();
    chk("rst_busy", busy, 1);
    chk("rst_ready", bus.cmd_ready, 0);
    chk("rst_fill_req", bus.fill_req, 0);
    chk("rst_fill_addr", bus.fill_addr, 0);
    chk("rst_rsp", bus.rsp_valid, 0);
    chk_cnt("rst", 0, 0, 0);
    rst_n = 1'b1;
    wait_sweep("poweron");
    chk_cnt("poweron", 0, 0, 0);

    for (int i = 0; i < 21; i++) begin
      send(tbl[i].c, tbl[i].a, h);
      if (tbl[i].c == CMD_INST_FETCH)
        chk($sformatf("vec%0d_hit", i), h, tbl[i].eh);
      if (tbl[i].ck)
        chk_cnt($sformatf("vec%0d", i), tbl[i].er, tbl[i].ehc, tbl[i].em);
    end

    send(CMD_RESET, 32'h0, h);
    chk_cnt("rstcmd", 0, 0, 0);
    chk("rstcmd_busy", busy, 1);
    chk("rstcmd_ready", bus.cmd_ready, 0);
    wait_sweep("rstcmd");
    send(CMD_INST_FETCH, 32'h1000, h);
    chk("rstcmd_refetch", h, 0);

    bus.cmd_valid = 1'b1;
    bus.cmd = CMD_INST_FETCH;
    bus.cmd_addr = 32'h1000;
    tick();
    chk("b2b_rsp0", bus.rsp_valid, 1);
    chk("b2b_hit0", bus.rsp_hit, 1);
    chk("b2b_ready", bus.cmd_ready, 1);
    tick();
    bus.cmd_valid = 1'b0;
    chk("b2b_rsp1", bus.rsp_valid, 1);
    chk("b2b_hit1", bus.rsp_hit, 1);
    tick();
    chk("b2b_idle", bus.rsp_valid, 0);
    chk_cnt("b2b", 3, 2, 1);

    bus.cmd_valid = 1'b1;
    bus.cmd = CMD_INST_FETCH;
    bus.cmd_addr = 32'h2000;
    tick();
    bus.cmd_valid = 1'b0;
    chk("arst_pre_req", bus.fill_req, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_req", bus.fill_req, 0);
    chk("arst_busy", busy, 1);
    chk("arst_ready", bus.cmd_ready, 0);
    chk("arst_rsp", bus.rsp_valid, 0);
    bus.fill_ack = 1'b1;
    repeat (2) tick();
    rst_n = 1'b1;
    wait_sweep("arst");
    bus.fill_ack = 1'b0;
    chk_cnt("arst", 0, 0, 0);
    send(CMD_INST_FETCH, 32'h2000, h);
    chk("arst_refetch", h, 0);
    chk_cnt("arst_end", 1, 0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
